// File: rtl/window_buffer_loader.sv
// Writer side of the 16 x 8-bit CNN window buffer: demuxes a valid/ready stream into slots 0..DEPTH-1.
// Optional short-window support (in_last, clear on release) is enabled by defining WIN_LOADER_PARTIAL_EN.
module window_buffer_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
`ifdef WIN_LOADER_PARTIAL_EN
  input  logic                    in_last,
`endif
  output logic                    in_ready,
  output logic [DEPTH*DATA_W-1:0] buf_data,
  output logic                    buf_full,
  input  logic                    buf_release,
  output logic [PTR_W-1:0]        wr_ptr
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
  logic                           close_window;

  // State, pointer and entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      ptr_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  // Window completes on the last slot, or early on in_last when short windows are enabled
`ifdef WIN_LOADER_PARTIAL_EN
  assign close_window = (ptr_q == LastPtr) || in_last;
`else
  assign close_window = (ptr_q == LastPtr);
`endif

  // Next-state, pointer and entry update; in FULL nothing is accepted and release takes priority
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          mem_d[ptr_q] = in_data;
          ptr_d        = ptr_q + PTR_W'(1);
          if (close_window) begin
            ptr_d   = '0;
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (buf_release) begin
          state_d = ST_FILL;
`ifdef WIN_LOADER_PARTIAL_EN
          mem_d   = '0;
`endif
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Handshake/status decode from the state register only
  assign in_ready = (state_q == ST_FILL);
  assign buf_full = (state_q == ST_FULL);
  assign buf_data = mem_q;
  assign wr_ptr   = ptr_q;

endmodule

// File: tb/tb_window_buffer_loader.sv
// Directed self-checking bench for window_buffer_loader; short-window checks run only with WIN_LOADER_PARTIAL_EN.
module tb_window_buffer_loader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic [DEPTH*DATA_W-1:0] buf_data;
  logic                    buf_full;
  logic                    buf_release;
  logic [PTR_W-1:0]        wr_ptr;
`ifdef WIN_LOADER_PARTIAL_EN
  logic                    in_last;
`endif

  int n_checks;
  int n_fail;

  window_buffer_loader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
`ifdef WIN_LOADER_PARTIAL_EN
    .in_last    (in_last),
`endif
    .in_ready   (in_ready),
    .buf_data   (buf_data),
    .buf_full   (buf_full),
    .buf_release(buf_release),
    .wr_ptr     (wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ent(input int i);
    return buf_data[i*DATA_W +: DATA_W];
  endfunction

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    buf_release = 1'b0;
`ifdef WIN_LOADER_PARTIAL_EN
    in_last     = 1'b0;
`endif
    #12;
    n_checks++;
    if (buf_data !== '0) begin
      n_fail++; $display("FAIL reset_buf_data: got %h expected 0", buf_data);
    end
    n_checks++;
    if (wr_ptr !== 4'd0) begin
      n_fail++; $display("FAIL reset_wr_ptr: got %0d expected 0", wr_ptr);
    end
    n_checks++;
    if (buf_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_buf_full: got %b expected 0", buf_full);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_fill_back_to_back();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      step();
      if (i == 14) begin
        n_checks++;
        if (buf_full !== 1'b0 || wr_ptr !== 4'd15) begin
          n_fail++; $display("FAIL fill_after15: got full=%b ptr=%0d expected full=0 ptr=15", buf_full, wr_ptr);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (buf_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_buf_full: got %b expected 1", buf_full);
    end
    n_checks++;
    if (wr_ptr !== 4'd0) begin
      n_fail++; $display("FAIL fill_wr_ptr: got %0d expected 0", wr_ptr);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ent(i) !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL fill_entry%0d: got %h expected %h", i, ent(i), 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_hold_in_full();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (buf_full !== 1'b1 || wr_ptr !== 4'd0) begin
        n_fail++; $display("FAIL hold_status_c%0d: got full=%b ptr=%0d expected full=1 ptr=0", c, buf_full, wr_ptr);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ent(i) !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL hold_entry%0d: got %h expected %h", i, ent(i), 8'(8'h10 + i));
      end
    end
    // Release with valid still held: release wins, AA lands on the following edge
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || buf_full !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got ready=%b full=%b expected ready=1 full=0", in_ready, buf_full);
    end
    n_checks++;
    if (ent(0) !== 8'h10 || wr_ptr !== 4'd0) begin
      n_fail++; $display("FAIL hold_release_noaccept: got e0=%h ptr=%0d expected e0=10 ptr=0", ent(0), wr_ptr);
    end
    step();
    n_checks++;
    if (ent(0) !== 8'hAA || wr_ptr !== 4'd1) begin
      n_fail++; $display("FAIL hold_aa_entry0: got e0=%h ptr=%0d expected e0=aa ptr=1", ent(0), wr_ptr);
    end
    for (int i = 1; i < 16; i++) begin
      in_data = 8'(8'h20 + i);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (buf_full !== 1'b1 || ent(1) !== 8'h21 || ent(15) !== 8'h2F) begin
      n_fail++; $display("FAIL hold_refill: got full=%b e1=%h e15=%h expected full=1 e1=21 e15=2f", buf_full, ent(1), ent(15));
    end
  endtask

  task automatic test_release_and_valid();
    buf_release = 1'b1;
    in_valid    = 1'b1;
    in_data     = 8'h55;
    step();
    buf_release = 1'b0;
    n_checks++;
    if (wr_ptr !== 4'd0 || ent(0) !== 8'hAA || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_release: got ptr=%0d e0=%h ready=%b expected ptr=0 e0=aa ready=1", wr_ptr, ent(0), in_ready);
    end
    in_data = 8'h66;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (ent(0) !== 8'h66 || wr_ptr !== 4'd1) begin
      n_fail++; $display("FAIL same_cycle_next: got e0=%h ptr=%0d expected e0=66 ptr=1", ent(0), wr_ptr);
    end
  endtask

  task automatic test_gaps();
    int gaps [16] = '{0, 3, 1, 2, 0, 0, 3, 1, 2, 1, 0, 3, 2, 0, 1, 2};
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      for (int g = 0; g < gaps[i]; g++) step();
      n_checks++;
      if (wr_ptr !== 4'(i) || buf_full !== 1'b0) begin
        n_fail++; $display("FAIL gaps_ptr%0d: got ptr=%0d full=%b expected ptr=%0d full=0", i, wr_ptr, buf_full, i);
      end
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (buf_full !== 1'b1 || wr_ptr !== 4'd0) begin
      n_fail++; $display("FAIL gaps_full: got full=%b ptr=%0d expected full=1 ptr=0", buf_full, wr_ptr);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ent(i) !== 8'(8'h40 + i)) begin
        n_fail++; $display("FAIL gaps_entry%0d: got %h expected %h", i, ent(i), 8'(8'h40 + i));
      end
    end
    // Release in FILL is ignored
    buf_release = 1'b1;
    step();
    step();
    buf_release = 1'b0;
    n_checks++;
    if (buf_full !== 1'b0 || in_ready !== 1'b1 || ent(3) !== (
`ifdef WIN_LOADER_PARTIAL_EN
        8'h00
`else
        8'h43
`endif
        )) begin
      n_fail++; $display("FAIL gaps_release: got full=%b ready=%b e3=%h", buf_full, in_ready, ent(3));
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h01 + i);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (wr_ptr !== 4'd7 || ent(6) !== 8'h07) begin
      n_fail++; $display("FAIL midreset_pre: got ptr=%0d e6=%h expected ptr=7 e6=07", wr_ptr, ent(6));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (buf_data !== '0 || wr_ptr !== 4'd0 || buf_full !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: got data=%h ptr=%0d full=%b expected all 0", buf_data, wr_ptr, buf_full);
    end
    #3;
    rst_n = 1'b1;
    step();
  endtask

`ifdef WIN_LOADER_PARTIAL_EN
  task automatic test_partial();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + i);
      step();
    end
    in_valid    = 1'b0;
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
    n_checks++;
    if (buf_data !== '0 || buf_full !== 1'b0) begin
      n_fail++; $display("FAIL partial_release_clear: got data=%h full=%b expected 0", buf_data, buf_full);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h31 + i);
      in_last  = (i == 4);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (buf_full !== 1'b1 || wr_ptr !== 4'd0) begin
      n_fail++; $display("FAIL partial_full: got full=%b ptr=%0d expected full=1 ptr=0", buf_full, wr_ptr);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ent(i) !== ((i < 5) ? 8'(8'h31 + i) : 8'h00)) begin
        n_fail++; $display("FAIL partial_entry%0d: got %h expected %h", i, ent(i), ((i < 5) ? 8'(8'h31 + i) : 8'h00));
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_back_to_back();
    test_hold_in_full();
    test_release_and_valid();
    test_gaps();
    test_reset_mid_fill();
`ifdef WIN_LOADER_PARTIAL_EN
    test_partial();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
